// File: rtl/alu_muldiv_pkg.sv
// Shared constants for the execute-stage ALU with iterative multiply/divide.
// Holds funct3 encodings for base and M-extension ops and the controller state encodings.
// No logic; imported by alu_muldiv and muldiv_core.
package alu_muldiv_pkg;

    // Base ALU funct3 encodings (func_sel picks SUB / SRA / ANDN alternates)
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SLL  = 3'd1;
    localparam logic [2:0] ALU_SLT  = 3'd2;
    localparam logic [2:0] ALU_SLTU = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SRL  = 3'd5;
    localparam logic [2:0] ALU_OR   = 3'd6;
    localparam logic [2:0] ALU_AND  = 3'd7;

    // M-extension funct3 encodings; bit 2 set means a divide-family op,
    // bit 1 set (within the divide family) means the remainder is returned
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    // Controller state encodings
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_BASE_DONE = 3'd1;
    localparam logic [2:0] S_MUL       = 3'd2;
    localparam logic [2:0] S_DIV       = 3'd3;
    localparam logic [2:0] S_FIX       = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    function automatic logic md_is_div(input logic [2:0] f);
        return f[2];
    endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// muldiv_core: iterative shift-add multiplier / restoring divider on operand magnitudes, UNROLL bits per cycle.
// Latency: start -> last iteration after XLEN/UNROLL cycles, done (sign-fixed result valid) the cycle after.
// Backpressure: none; the controller only starts it when idle and samples result while done is high.
// Ports: clk, reset_n, start/kill controls, func + in1/in2 operands at start; busy, last, done, result.
module muldiv_core
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      func,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            busy,
    output logic            last,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int ITER = XLEN / UNROLL;
    localparam int CW   = $clog2(ITER + 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   opd_q, opd_d;     // mul: multiplicand magnitude; div: divisor magnitude
    logic              is_div_q, is_div_d;
    logic [2:0]        func_q, func_d;
    logic              neg_q, neg_d;     // negate product / quotient in FIX
    logic              rneg_q, rneg_d;   // negate remainder in FIX
    logic              fix_q, fix_d;

    logic              sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0]   mag1, mag2;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN:0]     sum, t, diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo, rem;

    // Operand signedness and magnitudes at start
    always_comb begin
        if (md_is_div(func)) begin
            sgn1 = (func == MD_DIV) || (func == MD_REM);
            sgn2 = sgn1;
        end else begin
            sgn1 = (func != MD_MULHU);
            sgn2 = (func == MD_MUL) || (func == MD_MULH);
        end
        neg1 = sgn1 & in1[XLEN-1];
        neg2 = sgn2 & in2[XLEN-1];
        mag1 = neg1 ? -in1 : in1;
        mag2 = neg2 ? -in2 : in2;
    end

    // UNROLL iteration steps chained combinationally
    always_comb begin
        acc_step = acc_q;
        sum      = '0;
        t        = '0;
        diff     = '0;
        for (int u = 0; u < UNROLL; u++) begin
            if (is_div_q) begin
                // Shift the next dividend bit into the remainder and try a subtract
                t    = {acc_step[2*XLEN-1:XLEN], acc_step[XLEN-1]};
                diff = t - {1'b0, opd_q};
                if (!diff[XLEN]) begin
                    acc_step = {diff[XLEN-1:0], acc_step[XLEN-2:0], 1'b1};
                end else begin
                    acc_step = {t[XLEN-1:0], acc_step[XLEN-2:0], 1'b0};
                end
            end else begin
                // Add multiplicand when the multiplier LSB is set, then shift right;
                // the carry out of the add becomes the new top bit
                sum      = {1'b0, acc_step[2*XLEN-1:XLEN]} + (acc_step[0] ? {1'b0, opd_q} : '0);
                acc_step = {sum, acc_step[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        func_d   = func_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        fix_d    = 1'b0;
        if (kill) begin
            cnt_d = '0;
        end else if (start) begin
            cnt_d    = CW'(ITER);
            is_div_d = md_is_div(func);
            func_d   = func;
            opd_d    = md_is_div(func) ? mag2 : mag1;
            acc_d    = md_is_div(func) ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
            neg_d    = neg1 ^ neg2;
            rneg_d   = neg1;
        end else if (cnt_q != '0) begin
            acc_d = acc_step;
            cnt_d = cnt_q - 1'b1;
            fix_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            func_q   <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            fix_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            func_q   <= func_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            fix_q    <= fix_d;
        end
    end

    // Sign fix-up and half/quotient/remainder selection
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo      = acc_q[XLEN-1:0];
        rem      = acc_q[2*XLEN-1:XLEN];
        if (is_div_q) begin
            if (func_q[1]) begin
                result = rneg_q ? -rem : rem;
            end else begin
                result = neg_q ? -quo : quo;
            end
        end else begin
            result = (func_q == MD_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    assign busy = (cnt_q != '0);
    assign last = (cnt_q == CW'(1));
    assign done = fix_q;

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: RV32I base ALU plus M-extension mul/div behind valid/ready, with flush (kill).
// Latency: base ops and div-by-zero/overflow 1 cycle; mul/div XLEN/UNROLL+2 cycles after accept.
// Backpressure: result held until out_ready; in_ready low while busy or holding a result.
// Ports: clk, reset_n; in_valid/in_ready, in1, in2, func, func_sel, md_sel, kill; out_valid/out_ready, out.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [2:0]      func,
    input  logic            func_sel,
    input  logic            md_sel,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out
);

    localparam int SW = $clog2(XLEN);

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] out_q, out_d;
    logic            out_valid_q, out_valid_d;

    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] base_res, special_res;
    logic            div_zero, div_ovf, md_special;
    logic            accept, md_start;
    logic            md_busy, md_last, md_done;
    logic [XLEN-1:0] md_result;

    assign shamt = in2[SW-1:0];

    always_comb begin
        case (func)
            ALU_ADD:  base_res = func_sel ? (in1 - in2) : (in1 + in2);
            ALU_SLL:  base_res = in1 << shamt;
            ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
            ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, (in1 < in2)};
            ALU_XOR:  base_res = in1 ^ in2;
            ALU_SRL:  base_res = func_sel ? XLEN'($signed(in1) >>> shamt) : (in1 >> shamt);
            ALU_OR:   base_res = in1 | in2;
            ALU_AND:  base_res = func_sel ? (in1 & ~in2) : (in1 & in2);
            default:  base_res = '0;
        endcase
    end

    // Divide cases with a fixed answer bypass the iterative core
    always_comb begin
        div_zero   = (in2 == '0);
        div_ovf    = ((func == MD_DIV) || (func == MD_REM)) &&
                     (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1);
        md_special = md_is_div(func) && (div_zero || div_ovf);
        if (func[1]) begin
            special_res = div_zero ? in1 : '0;
        end else begin
            special_res = div_zero ? '1 : in1;
        end
    end

    assign in_ready = (state_q == S_IDLE) && !out_valid_q;
    assign accept   = in_valid && in_ready && !kill;
    assign md_start = accept && md_sel && !md_special;

    muldiv_core #(
        .XLEN   (XLEN),
        .UNROLL (UNROLL)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (md_start),
        .kill    (kill),
        .func    (func),
        .in1     (in1),
        .in2     (in2),
        .busy    (md_busy),
        .last    (md_last),
        .done    (md_done),
        .result  (md_result)
    );

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!md_sel || md_special) begin
                        state_d     = S_BASE_DONE;
                        out_d       = md_sel ? special_res : base_res;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = md_is_div(func) ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (md_last) begin
                    state_d = S_FIX;
                end else if (!md_busy) begin
                    // Core lost its operation (cannot happen without kill); recover to idle
                    state_d = S_IDLE;
                end
            end
            S_FIX: begin
                if (md_done) begin
                    out_d       = md_result;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BASE_DONE, S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        // Flush wins over everything: drop any pending result or iteration
        if (kill) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Testbench for alu_muldiv: directed and random ops against an arithmetic reference model.
// Two instances: UNROLL=1 (main) and UNROLL=4 sharing operand inputs but with separate in_valid.
// Prints one TB_RESULT summary line.
module tb_alu_muldiv;

    logic        clk;
    logic        reset_n;
    logic        in_valid, in_valid4;
    logic        in_ready, in_ready4;
    logic [31:0] in1, in2;
    logic [2:0]  func;
    logic        func_sel, md_sel, kill, out_ready;
    logic        out_valid, out_valid4;
    logic [31:0] dout, dout4;

    int checks   = 0;
    int failures = 0;

    alu_muldiv #(.XLEN(32), .UNROLL(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .func(func), .func_sel(func_sel), .md_sel(md_sel),
        .kill(kill), .out_valid(out_valid), .out_ready(out_ready), .out(dout)
    );

    alu_muldiv #(.XLEN(32), .UNROLL(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in1(in1), .in2(in2), .func(func), .func_sel(func_sel), .md_sel(md_sel),
        .kill(kill), .out_valid(out_valid4), .out_ready(out_ready), .out(dout4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V semantics from plain integer arithmetic
    function automatic logic [31:0] ref_model(input bit md, input bit fsel, input logic [2:0] f,
                                              input logic [31:0] a, input logic [31:0] b);
        longint          x, y;
        longint unsigned ux, uy;
        logic [63:0]     p;
        int              sa, sb;
        bit              ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (!md) begin
            case (f)
                3'd0: return fsel ? a - b : a + b;
                3'd1: return a << b[4:0];
                3'd2: return (sa < sb) ? 32'd1 : 32'd0;
                3'd3: return (a < b) ? 32'd1 : 32'd0;
                3'd4: return a ^ b;
                3'd5: return fsel ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                3'd6: return a | b;
                default: return fsel ? a & ~b : a & b;
            endcase
        end
        case (f)
            3'd0: return a * b;
            3'd1: begin x = sa; y = sb; p = x * y; return p[63:32]; end
            3'd2: begin x = sa; y = {32'd0, b}; p = x * y; return p[63:32]; end
            3'd3: begin ux = {32'd0, a}; uy = {32'd0, b}; p = ux * uy; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input bit md, input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b, input int iters);
        if (!md) return 1;
        if (f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return iters + 2;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op at the current negedge (block must be idle), wait for the result,
    // check latency and value, retire it, and end at the negedge after retirement.
    task automatic do_op(input bit u4, input string tag, input bit md, input bit fsel,
                         input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        int cyc;
        check_eq({tag, "_rdy"}, {31'd0, u4 ? in_ready4 : in_ready}, 32'd1);
        md_sel = md; func_sel = fsel; func = f; in1 = a; in2 = b; out_ready = 1'b1;
        if (u4) in_valid4 = 1'b1; else in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_valid4 = 1'b0;
        in1 = $urandom; in2 = $urandom;
        cyc = 1;
        while (!(u4 ? out_valid4 : out_valid) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_lat"}, 32'(cyc), 32'(lat));
        check_eq({tag, "_out"}, u4 ? dout4 : dout, exp);
        @(negedge clk);
    endtask

    task automatic rand_op(input bit u4, input int iters);
        bit          md, fs;
        logic [2:0]  f;
        logic [31:0] a, b;
        md = 1'($urandom_range(0, 1));
        fs = 1'($urandom_range(0, 1));
        f  = 3'($urandom_range(0, 7));
        a  = pick_operand();
        b  = pick_operand();
        do_op(u4, "rand", md, fs, f, a, b, ref_model(md, fs, f, a, b), ref_lat(md, f, a, b, iters));
    endtask

    initial begin
        int          rises;
        int          cyc;
        logic [31:0] hold;

        reset_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; in1 = '0; in2 = '0;
        func = '0; func_sel = 1'b0; md_sel = 1'b0; kill = 1'b0; out_ready = 1'b1;
        #12;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out", dout, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_valid", {31'd0, out_valid}, 32'd0);

        // Directed cases with hand-derived expectations
        do_op(0, "add_ovf", 0, 0, 3'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
        do_op(0, "slt",     0, 0, 3'd2, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
        do_op(0, "sltu",    0, 0, 3'd3, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        do_op(0, "sub",     0, 1, 3'd0, 32'h5, 32'h7, 32'hFFFF_FFFE, 1);
        do_op(0, "sra",     0, 1, 3'd5, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
        do_op(0, "andn",    0, 1, 3'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF000_F000, 1);
        do_op(0, "mulh",    1, 0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        do_op(0, "mulhsu",  1, 0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        do_op(0, "mul_lo",  1, 0, 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0, 34);
        do_op(0, "mul_fs",  1, 1, 3'd0, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFEB, 34);
        do_op(0, "div",     1, 0, 3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 34);
        do_op(0, "rem",     1, 0, 3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 34);
        do_op(0, "divu0",   1, 0, 3'd5, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1);
        do_op(0, "rem_ovf", 1, 0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        do_op(0, "div_ovf", 1, 0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op(0, "remu0",   1, 0, 3'd7, 32'h1234_5678, 32'h0, 32'h1234_5678, 1);

        // Back-pressure on a DIV result
        check_eq("bp_rdy", {31'd0, in_ready}, 32'd1);
        md_sel = 1'b1; func_sel = 1'b0; func = 3'd4; in1 = 32'hFFFF_FF9C; in2 = 32'd7;
        out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("bp_lat", 32'(cyc), 32'd34);
        check_eq("bp_out", dout, 32'hFFFF_FFF2);
        hold = dout;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_hold_out", dout, hold);
            check_eq("bp_hold_vld", {31'd0, out_valid}, 32'd1);
            check_eq("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_retired", {31'd0, out_valid}, 32'd0);
        do_op(0, "bp_next", 0, 0, 3'd0, 32'd10, 32'd20, 32'd30, 1);

        // Kill with a concurrent request while idle: request must be dropped
        md_sel = 1'b0; func = 3'd0; in1 = 32'd1; in2 = 32'd1; in_valid = 1'b1; kill = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; kill = 1'b0;
        check_eq("kill_idle_vld", {31'd0, out_valid}, 32'd0);
        check_eq("kill_idle_rdy", {31'd0, in_ready}, 32'd1);

        // Kill in cycle N+10 of a DIV
        md_sel = 1'b1; func = 3'd4; in1 = 32'd1000; in2 = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        md_sel = 1'b0; func = 3'd0; in1 = 32'd2; in2 = 32'd2; in_valid = 1'b1;
        @(negedge clk);
        kill = 1'b0; in_valid = 1'b0;
        check_eq("kill_rdy", {31'd0, in_ready}, 32'd1);
        check_eq("kill_vld", {31'd0, out_valid}, 32'd0);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) rises++;
        end
        check_eq("kill_no_result", 32'(rises), 32'd0);
        do_op(0, "kill_next", 0, 0, 3'd0, 32'd1, 32'd2, 32'd3, 1);

        // Asynchronous reset in the middle of a MULHU
        md_sel = 1'b1; func = 3'd3; in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_vld", {31'd0, out_valid}, 32'd0);
        check_eq("arst_out", dout, 32'd0);
        check_eq("arst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) rises++;
        end
        check_eq("arst_no_result", 32'(rises), 32'd0);
        do_op(0, "arst_next", 0, 0, 3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1);

        // UNROLL=4 instance
        do_op(1, "divu4", 1, 0, 3'd5, 32'd100, 32'd7, 32'd14, 10);
        for (int i = 0; i < 15; i++) rand_op(1, 8);

        // Randomised ops on the UNROLL=1 instance
        for (int i = 0; i < 60; i++) rand_op(0, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
